fp_norm_pipe: RTL and testbench

FP_NORM_PIPE -- requirements
Module: fp_norm_pipe

---
 rtl/fp_norm_pipe.sv | 234 +++++++++++++++++++++++
 tb/tb_fp_norm_pipe.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_norm_pipe.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// fp_norm_pipe
//
// Purpose
//   Two-stage normalisation pipeline for the unnormalised sum coming out of
//   a floating-point adder. The significand carries one carry bit on top
//   (bit MAN_W-1) above the hidden-bit position (bit MAN_W-2).
//     * Carry set   : shift right by one, bump the exponent (saturating).
//     * Carry clear : shift left by the leading-zero count, limited by the
//                     exponent so the exponent never goes below zero.
//     * Zero input  : flagged and forced to an all-zero result.
//
//   Stage 1 counts leading zeros and registers them with the raw beat.
//   Stage 2 applies the shift, adjusts the exponent and registers the flags.
//
// Handshake (both ports)
//   A beat moves across a port only on a rising edge where valid and ready
//   are both 1. A producer holding valid=1 keeps its payload stable until
//   the beat is taken; this block keeps every out_* signal stable while
//   out_valid=1 and out_ready=0. Each stage loads when it is empty or when
//   its current beat moves forward on the same edge, so the pipe runs at
//   one beat per cycle while out_ready=1. in_ready is "stage 1 can load".
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous, active-high; clears both stages. While high,
//                in_ready, out_valid and every out_* signal read 0.
//   in_valid   : input beat present
//   in_ready   : input beat accepted this cycle
//   in_man     : unnormalised significand [MAN_W-1:0]
//   in_exp     : biased exponent before adjustment [EXP_W-1:0]
//   out_valid  : result beat present
//   out_ready  : downstream accepts the result beat
//   out_man    : normalised significand (bit MAN_W-1 always 0)
//   out_exp    : adjusted exponent
//   out_shift  : applied shift magnitude [SH_W-1:0]
//   out_rshift : 1 = right shift by 1, 0 = left shift by out_shift
//   out_zero   : in_man was all zeros
//   out_sticky : a 1 was shifted out by the right shift
//   out_ovf    : exponent reached all-ones after the right shift
//   out_uflow  : left shift was clamped by the exponent
// ---------------------------------------------------------------------------
module fp_norm_pipe #(
    parameter int MAN_W = 25,
    parameter int EXP_W = 8,
    localparam int SH_W = $clog2(MAN_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAN_W-1:0] in_man,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAN_W-1:0] out_man,
    output logic [EXP_W-1:0] out_exp,
    output logic [SH_W-1:0]  out_shift,
    output logic             out_rshift,
    output logic             out_zero,
    output logic             out_sticky,
    output logic             out_ovf,
    output logic             out_uflow
);

    // Common width for comparing the leading-zero count with the exponent.
    localparam int CMP_W = (SH_W > EXP_W) ? SH_W : EXP_W;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    // -----------------------------------------------------------------------
    // Stage registers
    // -----------------------------------------------------------------------
    logic             s1_valid;
    logic [MAN_W-1:0] s1_man;
    logic [EXP_W-1:0] s1_exp;
    logic [SH_W-1:0]  s1_lzc;
    logic             s1_carry;

    logic             s2_valid;
    logic [MAN_W-1:0] s2_man;
    logic [EXP_W-1:0] s2_exp;
    logic [SH_W-1:0]  s2_shift;
    logic             s2_rshift;
    logic             s2_zero;
    logic             s2_sticky;
    logic             s2_ovf;
    logic             s2_uflow;

    // -----------------------------------------------------------------------
    // Flow control
    // -----------------------------------------------------------------------
    logic s1_load;
    logic s2_load;

    assign s2_load  = !s2_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = !rst && s1_load;

    // -----------------------------------------------------------------------
    // Stage 1: leading-zero count from the hidden-bit position downward.
    // Scanning upward lets the highest set bit win; an all-zero significand
    // leaves the count at MAN_W-1, which stage 2 never uses because the
    // zero case is handled separately.
    // -----------------------------------------------------------------------
    logic [SH_W-1:0] lzc_c;

    always_comb begin
        lzc_c = SH_W'(MAN_W - 1);
        for (int i = 0; i <= MAN_W - 2; i++) begin
            if (in_man[i]) begin
                lzc_c = SH_W'(MAN_W - 2 - i);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: shift and exponent adjustment.
    // The left shift is min(lzc, exp), so the exponent subtraction can never
    // go below zero; when the exponent is the limit the result is left
    // partly unnormalised and out_uflow reports it.
    // -----------------------------------------------------------------------
    logic [CMP_W-1:0] lzc_x;
    logic [CMP_W-1:0] exp_x;
    logic [CMP_W-1:0] sh_x;
    logic [CMP_W-1:0] exp_dec_x;
    logic             clamp;
    logic [EXP_W-1:0] exp_inc;

    assign lzc_x     = CMP_W'(s1_lzc);
    assign exp_x     = CMP_W'(s1_exp);
    assign clamp     = lzc_x > exp_x;
    assign sh_x      = clamp ? exp_x : lzc_x;
    assign exp_dec_x = exp_x - sh_x;
    // Saturating increment for the carry case.
    assign exp_inc   = (s1_exp == EXP_MAX) ? EXP_MAX : s1_exp + 1'b1;

    logic [MAN_W-1:0] n_man;
    logic [EXP_W-1:0] n_exp;
    logic [SH_W-1:0]  n_shift;
    logic             n_rshift;
    logic             n_zero;
    logic             n_sticky;
    logic             n_ovf;
    logic             n_uflow;

    always_comb begin
        n_man    = '0;
        n_exp    = '0;
        n_shift  = '0;
        n_rshift = 1'b0;
        n_zero   = 1'b0;
        n_sticky = 1'b0;
        n_ovf    = 1'b0;
        n_uflow  = 1'b0;
        if (s1_man == '0) begin
            n_zero = 1'b1;
        end else if (s1_carry) begin
            n_man    = s1_man >> 1;
            n_exp    = exp_inc;
            n_shift  = SH_W'(1);
            n_rshift = 1'b1;
            n_sticky = s1_man[0];
            n_ovf    = (exp_inc == EXP_MAX);
        end else begin
            // sh_x never exceeds the count, so it always fits in SH_W bits.
            n_man   = s1_man << sh_x;
            n_exp   = exp_dec_x[EXP_W-1:0];
            n_shift = sh_x[SH_W-1:0];
            n_uflow = clamp;
        end
    end

    // -----------------------------------------------------------------------
    // Pipeline registers. Payload only loads alongside a valid beat, so a
    // stalled stage 2 keeps its outputs untouched.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_man    <= '0;
            s1_exp    <= '0;
            s1_lzc    <= '0;
            s1_carry  <= 1'b0;
            s2_valid  <= 1'b0;
            s2_man    <= '0;
            s2_exp    <= '0;
            s2_shift  <= '0;
            s2_rshift <= 1'b0;
            s2_zero   <= 1'b0;
            s2_sticky <= 1'b0;
            s2_ovf    <= 1'b0;
            s2_uflow  <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_man   <= in_man;
                    s1_exp   <= in_exp;
                    s1_lzc   <= lzc_c;
                    s1_carry <= in_man[MAN_W-1];
                end
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_man    <= n_man;
                    s2_exp    <= n_exp;
                    s2_shift  <= n_shift;
                    s2_rshift <= n_rshift;
                    s2_zero   <= n_zero;
                    s2_sticky <= n_sticky;
                    s2_ovf    <= n_ovf;
                    s2_uflow  <= n_uflow;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. Masked by rst so the port reads idle during the whole reset
    // cycle, including the one before the first clearing edge.
    // -----------------------------------------------------------------------
    assign out_valid  = s2_valid && !rst;
    assign out_man    = rst ? '0 : s2_man;
    assign out_exp    = rst ? '0 : s2_exp;
    assign out_shift  = rst ? '0 : s2_shift;
    assign out_rshift = s2_rshift && !rst;
    assign out_zero   = s2_zero && !rst;
    assign out_sticky = s2_sticky && !rst;
    assign out_ovf    = s2_ovf && !rst;
    assign out_uflow  = s2_uflow && !rst;

endmodule

// File: tb/tb_fp_norm_pipe.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_fp_norm_pipe
//
// Bench for fp_norm_pipe (MAN_W=25, EXP_W=8). Inputs change 1 ns after the
// rising edge; outputs and handshakes are sampled on the falling edge.
// Expected results come from fixed constants for the hand-worked vectors
// and from an arithmetic reference model for random beats; the driver
// pushes each accepted beat's expected result onto exp_q and the monitor
// pops it when the beat leaves.
// ---------------------------------------------------------------------------
module tb_fp_norm_pipe;

  localparam int MAN_W = 25;
  localparam int EXP_W = 8;
  localparam int SH_W  = $clog2(MAN_W);
  localparam int RW    = MAN_W + EXP_W + SH_W + 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             in_valid;
  logic             in_ready;
  logic [MAN_W-1:0] in_man;
  logic [EXP_W-1:0] in_exp;
  logic             out_valid;
  logic             out_ready;
  logic [MAN_W-1:0] out_man;
  logic [EXP_W-1:0] out_exp;
  logic [SH_W-1:0]  out_shift;
  logic             out_rshift;
  logic             out_zero;
  logic             out_sticky;
  logic             out_ovf;
  logic             out_uflow;

  fp_norm_pipe #(.MAN_W(MAN_W), .EXP_W(EXP_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_man     (in_man),
    .in_exp     (in_exp),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_man    (out_man),
    .out_exp    (out_exp),
    .out_shift  (out_shift),
    .out_rshift (out_rshift),
    .out_zero   (out_zero),
    .out_sticky (out_sticky),
    .out_ovf    (out_ovf),
    .out_uflow  (out_uflow)
  );

  // ---------------- scoreboard state ----------------
  logic [RW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [RW-1:0] pack(input logic [MAN_W-1:0] m, input logic [EXP_W-1:0] e,
                                          input logic [SH_W-1:0] s, input logic r, input logic z,
                                          input logic st, input logic o, input logic u);
    return {m, e, s, r, z, st, o, u};
  endfunction

  // Reference model: works on plain integers from the normalisation rules.
  function automatic logic [RW-1:0] model(input logic [MAN_W-1:0] m, input logic [EXP_W-1:0] e);
    longint mv   = longint'(m);
    longint ev   = longint'(e);
    longint emax = (longint'(1) << EXP_W) - 1;
    longint top  = longint'(1) << (MAN_W - 1);
    longint lz;
    longint sh;
    longint ne;
    if (mv == 0)
      return pack('0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    if (mv >= top) begin
      ne = ev + 1;
      if (ne > emax) ne = emax;
      return pack(MAN_W'(mv / 2), EXP_W'(ne), SH_W'(1), 1'b1, 1'b0,
                  (mv % 2) == 1, ne == emax, 1'b0);
    end
    // Doubling until the value reaches the hidden-bit weight gives the count.
    lz = 0;
    while (mv * (longint'(1) << lz) < top / 2) lz++;
    sh = (lz < ev) ? lz : ev;
    return pack(MAN_W'(mv * (longint'(1) << sh)), EXP_W'(ev - sh), SH_W'(sh),
                1'b0, 1'b0, 1'b0, 1'b0, lz > ev);
  endfunction

  function automatic logic [MAN_W-1:0] gen_man();
    int mode = $urandom_range(0, 9);
    int b;
    logic [31:0] r = $urandom;
    logic [MAN_W-1:0] m;
    if (mode == 0) begin
      m = '0;
    end else if (mode <= 2) begin
      m = MAN_W'(r);
      m[MAN_W-1] = 1'b1;
    end else if (mode <= 6) begin
      b = $urandom_range(0, MAN_W - 2);
      m = MAN_W'((longint'(1) << b) | (longint'(r) & ((longint'(1) << b) - 1)));
    end else begin
      m = MAN_W'(r);
    end
    return m;
  endfunction

  function automatic logic [EXP_W-1:0] gen_exp();
    int mode = $urandom_range(0, 5);
    logic [EXP_W-1:0] e;
    case (mode)
      0:       e = '0;
      1:       e = EXP_W'(1);
      2:       e = EXP_W'($urandom_range(253, 255));
      3:       e = EXP_W'($urandom_range(0, 30));
      default: e = EXP_W'($urandom_range(0, 255));
    endcase
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [MAN_W-1:0] m, input logic [EXP_W-1:0] e, input logic [RW-1:0] want);
    bit ok = 0;
    in_valid = 1'b1;
    in_man   = m;
    in_exp   = e;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(want);
        ok = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_rand();
    logic [MAN_W-1:0] m = gen_man();
    logic [EXP_W-1:0] e = gen_exp();
    send(m, e, model(m, e));
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- monitor ----------------
  logic [RW-1:0] cur_out;
  logic [RW-1:0] prev_out;
  logic [RW-1:0] want_out;
  bit            hold_pending = 0;

  always @(negedge clk) begin
    cur_out = {out_man, out_exp, out_shift, out_rshift, out_zero, out_sticky, out_ovf, out_uflow};
    if (rst) begin
      hold_pending = 0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", 64'(cur_out), 64'(prev_out));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_beat", 64'(out_valid), 64'd0);
        end else begin
          want_out = exp_q.pop_front();
          check("beat", 64'(cur_out), 64'(want_out));
        end
      end
      hold_pending = out_valid && !out_ready;
      prev_out     = cur_out;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  bit done;
  logic [MAN_W-1:0] dm[9];
  logic [EXP_W-1:0] de[9];
  logic [RW-1:0]    dx[9];

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_man    = '0;
    in_exp    = '0;
    out_ready = 1'b1;

    // Directed vectors with hand-worked results.
    dm[0] = 25'h0800000; de[0] = 8'd100; dx[0] = pack(25'h0800000, 8'd100, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    dm[1] = 25'h0000001; de[1] = 8'd100; dx[1] = pack(25'h0800000, 8'd77,  5'd23, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    dm[2] = 25'h1000001; de[2] = 8'd254; dx[2] = pack(25'h0800000, 8'd255, 5'd1,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    dm[3] = 25'h0000100; de[3] = 8'd10;  dx[3] = pack(25'h0040000, 8'd0,   5'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    dm[4] = 25'h0000000; de[4] = 8'd57;  dx[4] = pack(25'h0000000, 8'd0,   5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    dm[5] = 25'h1FFFFFF; de[5] = 8'd255; dx[5] = pack(25'h0FFFFFF, 8'd255, 5'd1,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    dm[6] = 25'h1000000; de[6] = 8'd3;   dx[6] = pack(25'h0800000, 8'd4,   5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    dm[7] = 25'h0400000; de[7] = 8'd0;   dx[7] = pack(25'h0400000, 8'd0,   5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    dm[8] = 25'h0000003; de[8] = 8'd30;  dx[8] = pack(25'h0C00000, 8'd8,   5'd22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_outputs", 64'({out_man, out_exp, out_shift, out_rshift, out_zero, out_sticky, out_ovf, out_uflow}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", 64'(in_ready), 64'd1);
    check("valid_after_rst", 64'(out_valid), 64'd0);

    // Directed vectors, back to back.
    for (int i = 0; i < 9; i++) send(dm[i], de[i], dx[i]);
    drain();

    // Stall: two beats fill the pipe, a third waits for 4 blocked cycles.
    out_ready = 1'b0;
    send_rand();
    check("ready_one_held", 64'(in_ready), 64'd1);
    send_rand();
    check("ready_two_held", 64'(in_ready), 64'd0);
    fork
      send_rand();
      begin
        repeat (4) begin
          @(negedge clk);
          check("stall_ready_low", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    send_rand();
    drain();

    // Random traffic with random back-pressure.
    done = 0;
    fork
      begin
        for (int n = 0; n < 400; n++) begin
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clk);
            #1;
          end
          send_rand();
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset mid-stream: two held beats are discarded.
    out_ready = 1'b0;
    send_rand();
    send_rand();
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    exp_q.delete();
    rst       = 1'b0;
    out_ready = 1'b1;
    check("post_rst_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("post_rst_ready", 64'(in_ready), 64'd1);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 20; i++) send_rand();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
